// File: rtl/wb_regfile_commit_if.sv
// ---------------------------------------------------------------------------
// wb_regfile_commit_if
// Bundle between the MEM/WB pipeline register, the decode stage, fetch and the
// writeback/register-file block.
//   W-stage inputs : ReadData, AluOutW, WA3W, PCSrcW, regWriteW, memToRegW,
//                    stallW
//   Decode reads   : PCPlus8D, RA1D, RA2D in; RD1D, RD2D out
//   Results        : ResultW (combinational), pc_redirect / pc_target
//                    (registered), retired (committed-instruction count)
// Modports: master drives the pipeline side, slave is the writeback block.
// ---------------------------------------------------------------------------
interface wb_regfile_commit_if #(
  parameter int DATA_W = 24,
  parameter int ALU_W  = 16,
  parameter int ADDR_W = 4,
  parameter int CNT_W  = 16
);
  logic [DATA_W-1:0] ReadData;
  logic [ALU_W-1:0]  AluOutW;
  logic [23:0]       WA3W;
  logic              PCSrcW;
  logic              regWriteW;
  logic              memToRegW;
  logic              stallW;
  logic [DATA_W-1:0] PCPlus8D;
  logic [ADDR_W-1:0] RA1D;
  logic [ADDR_W-1:0] RA2D;
  logic [DATA_W-1:0] RD1D;
  logic [DATA_W-1:0] RD2D;
  logic [DATA_W-1:0] ResultW;
  logic              pc_redirect;
  logic [DATA_W-1:0] pc_target;
  logic [CNT_W-1:0]  retired;

  modport master (
    output ReadData, AluOutW, WA3W, PCSrcW, regWriteW, memToRegW, stallW,
           PCPlus8D, RA1D, RA2D,
    input  RD1D, RD2D, ResultW, pc_redirect, pc_target, retired
  );

  modport slave (
    input  ReadData, AluOutW, WA3W, PCSrcW, regWriteW, memToRegW, stallW,
           PCPlus8D, RA1D, RA2D,
    output RD1D, RD2D, ResultW, pc_redirect, pc_target, retired
  );
endinterface

// File: rtl/wb_regfile_commit.sv
// ---------------------------------------------------------------------------
// wb_regfile_commit
// Writeback stage: selects ResultW from the W-stage bundle, commits it into
// the architectural register file, raises a registered one-cycle PC redirect
// and counts retired instructions. Provides two decode read ports with a
// same-cycle write-through bypass. Index PC_REG aliases the PC: it is never
// stored, and reads of it return PCPlus8D.
// Ports:
//   clk    in  single clock, all state updates on posedge
//   rst_n  in  asynchronous active-low reset
//   bus    slave modport of wb_regfile_commit_if (see that file)
// ---------------------------------------------------------------------------
module wb_regfile_commit #(
  parameter int DATA_W = 24,
  parameter int ALU_W  = 16,
  parameter int NREGS  = 16,
  parameter int ADDR_W = 4,
  parameter int PC_REG = 15,
  parameter int CNT_W  = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  wb_regfile_commit_if.slave     bus
);

  localparam int                NSTORE = NREGS - 1;
  localparam logic [ADDR_W-1:0] PC_IDX = ADDR_W'(PC_REG);

  // Register array: the PC alias slot is not stored.
  logic [DATA_W-1:0] regs_r [0:NSTORE-1];

  logic [DATA_W-1:0] result_s;
  logic [ADDR_W-1:0] idx_s;
  logic              wr_en_s;
  logic              redirect_s;
  logic              commit_s;
  logic [DATA_W-1:0] array_rd1_s;
  logic [DATA_W-1:0] array_rd2_s;
  logic [DATA_W-1:0] rd1_s;
  logic [DATA_W-1:0] rd2_s;
  logic              pc_redirect_r;
  logic [DATA_W-1:0] pc_target_r;
  logic [CNT_W-1:0]  retired_r;
  logic              unused_wa3w_s;

  // Only the low ADDR_W bits of the destination field select a register.
  assign idx_s         = bus.WA3W[ADDR_W-1:0];
  assign unused_wa3w_s = ^bus.WA3W[23:ADDR_W];

  // Writeback value select; the narrower ALU result is zero-extended.
  always_comb begin
    result_s = '0;
    if (bus.memToRegW) begin
      result_s = bus.ReadData;
    end else begin
      result_s = {{(DATA_W-ALU_W){1'b0}}, bus.AluOutW};
    end
  end

  // Commit qualifiers: a stall suppresses every side effect this cycle.
  always_comb begin
    wr_en_s    = 1'b0;
    redirect_s = 1'b0;
    commit_s   = 1'b0;
    if (!bus.stallW) begin
      wr_en_s    = bus.regWriteW && (idx_s != PC_IDX);
      redirect_s = bus.PCSrcW;
      commit_s   = bus.regWriteW || bus.PCSrcW;
    end else begin
      wr_en_s    = 1'b0;
      redirect_s = 1'b0;
      commit_s   = 1'b0;
    end
  end

  // Array read for both decode ports; unmatched indices (the PC slot) read 0.
  always_comb begin
    array_rd1_s = '0;
    array_rd2_s = '0;
    for (int i = 0; i < NSTORE; i++) begin
      array_rd1_s = (bus.RA1D == ADDR_W'(i)) ? regs_r[i] : array_rd1_s;
      array_rd2_s = (bus.RA2D == ADDR_W'(i)) ? regs_r[i] : array_rd2_s;
    end
  end

  // Read port 1: PC alias first, then write-through bypass, then the array.
  always_comb begin
    rd1_s = '0;
    if (bus.RA1D == PC_IDX) begin
      rd1_s = bus.PCPlus8D;
    end else if (wr_en_s && (bus.RA1D == idx_s)) begin
      rd1_s = result_s;
    end else begin
      rd1_s = array_rd1_s;
    end
  end

  // Read port 2: same priority as port 1.
  always_comb begin
    rd2_s = '0;
    if (bus.RA2D == PC_IDX) begin
      rd2_s = bus.PCPlus8D;
    end else if (wr_en_s && (bus.RA2D == idx_s)) begin
      rd2_s = result_s;
    end else begin
      rd2_s = array_rd2_s;
    end
  end

  // Register file write; writes aimed at the PC alias never reach the array.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NSTORE; i++) begin
        regs_r[i] <= '0;
      end
    end else if (wr_en_s) begin
      for (int i = 0; i < NSTORE; i++) begin
        if (idx_s == ADDR_W'(i)) begin
          regs_r[i] <= result_s;
        end else begin
          regs_r[i] <= regs_r[i];
        end
      end
    end else begin
      for (int i = 0; i < NSTORE; i++) begin
        regs_r[i] <= regs_r[i];
      end
    end
  end

  // PC redirect: one-cycle pulse per PCSrcW commit, target held between pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_redirect_r <= 1'b0;
      pc_target_r   <= '0;
    end else if (redirect_s) begin
      pc_redirect_r <= 1'b1;
      pc_target_r   <= result_s;
    end else begin
      pc_redirect_r <= 1'b0;
      pc_target_r   <= pc_target_r;
    end
  end

  // Retired-instruction counter; wraps naturally at 2^CNT_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired_r <= '0;
    end else if (commit_s) begin
      retired_r <= retired_r + CNT_W'(1);
    end else begin
      retired_r <= retired_r;
    end
  end

  assign bus.ResultW     = result_s;
  assign bus.RD1D        = rd1_s;
  assign bus.RD2D        = rd2_s;
  assign bus.pc_redirect = pc_redirect_r;
  assign bus.pc_target   = pc_target_r;
  assign bus.retired     = retired_r;

endmodule

// File: tb/tb_wb_regfile_commit.sv
module tb_wb_regfile_commit;
  localparam int DATA_W = 24;
  localparam int ALU_W  = 16;
  localparam int ADDR_W = 4;
  localparam int CNT_W  = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  wb_regfile_commit_if #(.DATA_W(DATA_W), .ALU_W(ALU_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus_if ();

  wb_regfile_commit #(
    .DATA_W(DATA_W), .ALU_W(ALU_W), .NREGS(16), .ADDR_W(ADDR_W), .PC_REG(15), .CNT_W(CNT_W)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_if)
  );

  int assert_cnt = 0;
  int fail_cnt   = 0;
  string       tag_q[$];
  logic [23:0] exp_q[$];
  logic [23:0] model [0:14];
  int          exp_retired;
  int          n_wrap;

  task automatic expect_val(input string tag, input logic [23:0] v);
    tag_q.push_back(tag);
    exp_q.push_back(v);
  endtask

  task automatic check_obs(input logic [23:0] obs);
    string       t;
    logic [23:0] e;
    assert_cnt++;
    if (exp_q.size() == 0) begin
      fail_cnt++;
      $error("FAIL scoreboard_empty observed=%h", obs);
    end else begin
      t = tag_q.pop_front();
      e = exp_q.pop_front();
      assert (obs === e) else begin
        fail_cnt++;
        $error("FAIL %s observed=%h expected=%h", t, obs, e);
      end
    end
  endtask

  task automatic idle();
    bus_if.ReadData  = 24'h000000;
    bus_if.AluOutW   = 16'h0000;
    bus_if.WA3W      = 24'h000000;
    bus_if.PCSrcW    = 1'b0;
    bus_if.regWriteW = 1'b0;
    bus_if.memToRegW = 1'b0;
    bus_if.stallW    = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    idle();
    bus_if.PCPlus8D = 24'h000000;
    bus_if.RA1D     = 4'd0;
    bus_if.RA2D     = 4'd0;
    for (int i = 0; i < 15; i++) model[i] = 24'h000000;
    exp_retired = 0;

    // Reset state
    #12;
    expect_val("rst_retired", 24'h000000);
    expect_val("rst_redirect", 24'h000000);
    expect_val("rst_target", 24'h000000);
    check_obs({8'h00, bus_if.retired});
    check_obs({23'h0, bus_if.pc_redirect});
    check_obs(bus_if.pc_target);
    @(negedge clk);
    rst_n = 1'b1;

    // All stored registers read 0; PC alias returns PCPlus8D
    tick();
    for (int i = 0; i < 15; i++) begin
      bus_if.RA1D = 4'(i);
      bus_if.RA2D = 4'(14 - i);
      expect_val($sformatf("init_rd1_r%0d", i), model[i]);
      expect_val($sformatf("init_rd2_r%0d", 14 - i), model[14 - i]);
      #1;
      check_obs(bus_if.RD1D);
      check_obs(bus_if.RD2D);
    end
    bus_if.RA1D     = 4'd15;
    bus_if.PCPlus8D = 24'h000108;
    expect_val("pc_alias_rd1", 24'h000108);
    #1;
    check_obs(bus_if.RD1D);

    // ALU write to r3 with same-cycle bypass
    tick();
    bus_if.regWriteW = 1'b1;
    bus_if.memToRegW = 1'b0;
    bus_if.AluOutW   = 16'hBEEF;
    bus_if.WA3W      = 24'h000003;
    bus_if.RA1D      = 4'd3;
    bus_if.RA2D      = 4'd4;
    expect_val("alu_result", 24'h00BEEF);
    expect_val("bypass_rd1", 24'h00BEEF);
    expect_val("no_bypass_rd2", 24'h000000);
    #1;
    check_obs(bus_if.ResultW);
    check_obs(bus_if.RD1D);
    check_obs(bus_if.RD2D);
    model[3] = 24'h00BEEF;
    exp_retired++;
    tick();
    idle();
    expect_val("r3_after_write", model[3]);
    expect_val("retired_1", 24'(exp_retired));
    #1;
    check_obs(bus_if.RD1D);
    check_obs({8'h00, bus_if.retired});

    // Load data to r5, upper WA3W bits ignored
    bus_if.regWriteW = 1'b1;
    bus_if.memToRegW = 1'b1;
    bus_if.ReadData  = 24'hABCDEF;
    bus_if.AluOutW   = 16'h1111;
    bus_if.WA3W      = 24'hFFFF05;
    expect_val("load_result", 24'hABCDEF);
    #1;
    check_obs(bus_if.ResultW);
    model[5] = 24'hABCDEF;
    exp_retired++;
    tick();
    idle();
    bus_if.RA1D = 4'd5;
    bus_if.RA2D = 4'd3;
    expect_val("r5_load", model[5]);
    expect_val("r3_kept", model[3]);
    expect_val("retired_2", 24'(exp_retired));
    #1;
    check_obs(bus_if.RD1D);
    check_obs(bus_if.RD2D);
    check_obs({8'h00, bus_if.retired});

    // Redirect with regWrite to PC alias: pulse only, array untouched
    bus_if.PCSrcW    = 1'b1;
    bus_if.regWriteW = 1'b1;
    bus_if.WA3W      = 24'h00000F;
    bus_if.AluOutW   = 16'h0400;
    expect_val("redir_result", 24'h000400);
    expect_val("redir_pre_edge", 24'h000000);
    #1;
    check_obs(bus_if.ResultW);
    check_obs({23'h0, bus_if.pc_redirect});
    exp_retired++;
    tick();
    idle();
    expect_val("redir_pulse", 24'h000001);
    expect_val("redir_target", 24'h000400);
    #1;
    check_obs({23'h0, bus_if.pc_redirect});
    check_obs(bus_if.pc_target);
    for (int i = 0; i < 15; i++) begin
      bus_if.RA1D = 4'(i);
      expect_val($sformatf("post_redir_r%0d", i), model[i]);
      #1;
      check_obs(bus_if.RD1D);
    end
    tick();
    expect_val("redir_end", 24'h000000);
    expect_val("target_hold", 24'h000400);
    expect_val("retired_3", 24'(exp_retired));
    #1;
    check_obs({23'h0, bus_if.pc_redirect});
    check_obs(bus_if.pc_target);
    check_obs({8'h00, bus_if.retired});

    // Back-to-back redirects; first also writes r7
    tick();
    bus_if.PCSrcW    = 1'b1;
    bus_if.regWriteW = 1'b1;
    bus_if.WA3W      = 24'h000007;
    bus_if.AluOutW   = 16'h0010;
    model[7] = 24'h000010;
    exp_retired++;
    tick();
    bus_if.regWriteW = 1'b0;
    bus_if.AluOutW   = 16'h0020;
    expect_val("b2b_pulse1", 24'h000001);
    expect_val("b2b_target1", 24'h000010);
    #1;
    check_obs({23'h0, bus_if.pc_redirect});
    check_obs(bus_if.pc_target);
    exp_retired++;
    tick();
    idle();
    bus_if.RA1D = 4'd7;
    expect_val("b2b_pulse2", 24'h000001);
    expect_val("b2b_target2", 24'h000020);
    expect_val("r7_with_redirect", model[7]);
    #1;
    check_obs({23'h0, bus_if.pc_redirect});
    check_obs(bus_if.pc_target);
    check_obs(bus_if.RD1D);
    tick();
    expect_val("b2b_end", 24'h000000);
    expect_val("b2b_target_hold", 24'h000020);
    #1;
    check_obs({23'h0, bus_if.pc_redirect});
    check_obs(bus_if.pc_target);

    // Stall: no write, no bypass, no redirect, counter holds
    bus_if.stallW    = 1'b1;
    bus_if.regWriteW = 1'b1;
    bus_if.PCSrcW    = 1'b1;
    bus_if.WA3W      = 24'h000002;
    bus_if.AluOutW   = 16'h1234;
    bus_if.RA1D      = 4'd2;
    expect_val("stall_result", 24'h001234);
    expect_val("stall_no_bypass", model[2]);
    #1;
    check_obs(bus_if.ResultW);
    check_obs(bus_if.RD1D);
    tick();
    idle();
    expect_val("stall_no_redirect", 24'h000000);
    expect_val("stall_target_hold", 24'h000020);
    expect_val("stall_retired", 24'(exp_retired));
    expect_val("stall_r2", model[2]);
    #1;
    check_obs({23'h0, bus_if.pc_redirect});
    check_obs(bus_if.pc_target);
    check_obs({8'h00, bus_if.retired});
    check_obs(bus_if.RD1D);

    // Drive the counter to its maximum with dropped PC-alias writes
    bus_if.regWriteW = 1'b1;
    bus_if.WA3W      = 24'h00000F;
    n_wrap = 65535 - exp_retired;
    repeat (n_wrap) @(posedge clk);
    #1;
    idle();
    exp_retired = 65535;
    expect_val("retired_max", 24'h00FFFF);
    #1;
    check_obs({8'h00, bus_if.retired});

    // Wrapping commit also redirects and writes r9
    bus_if.PCSrcW    = 1'b1;
    bus_if.regWriteW = 1'b1;
    bus_if.WA3W      = 24'h000009;
    bus_if.AluOutW   = 16'h0055;
    tick();
    idle();
    bus_if.RA1D = 4'd9;
    expect_val("retired_wrap", 24'h000000);
    expect_val("wrap_pulse", 24'h000001);
    expect_val("wrap_target", 24'h000055);
    expect_val("r9_written", 24'h000055);
    #1;
    check_obs({8'h00, bus_if.retired});
    check_obs({23'h0, bus_if.pc_redirect});
    check_obs(bus_if.pc_target);
    check_obs(bus_if.RD1D);

    // Asynchronous reset between edges clears state with no clock edge
    #1;
    rst_n = 1'b0;
    bus_if.AluOutW = 16'h0077;
    expect_val("async_rst_redirect", 24'h000000);
    expect_val("async_rst_target", 24'h000000);
    expect_val("async_rst_retired", 24'h000000);
    expect_val("async_rst_r9", 24'h000000);
    expect_val("async_rst_result_comb", 24'h000077);
    #1;
    check_obs({23'h0, bus_if.pc_redirect});
    check_obs(bus_if.pc_target);
    check_obs({8'h00, bus_if.retired});
    check_obs(bus_if.RD1D);
    check_obs(bus_if.ResultW);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end
endmodule
